// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a 4-entry TX FIFO.
// Registers: TXDATA (BASE) pushes a byte, STATUS (BASE+4) reports the
// FIFO/overflow state, CTRL (BASE+8) holds the enable bit and clears OVF.
module io_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [4:0]  BASE         = 5'h10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IOAdr,
    input  logic [31:0] WriteIO,
    input  logic        IOWrite,
    output logic [31:0] ReadIO,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned     CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]      ADR_TXDATA = BASE;
    localparam logic [4:0]      ADR_STATUS = BASE + 5'd4;
    localparam logic [4:0]      ADR_CTRL   = BASE + 5'd8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    fifo_mem [4];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic          en, ovf;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          pop, tx_n;
    logic          wr_txdata, wr_ctrl, push, full, empty;
    logic          unused_wdata;

    assign wr_txdata    = IOWrite && (IOAdr == ADR_TXDATA);
    assign wr_ctrl      = IOWrite && (IOAdr == ADR_CTRL);
    assign full         = (count == 3'd4);
    assign empty        = (count == 3'd0);
    // Fullness is judged on the count at the start of the cycle, so a pop
    // in the same cycle never makes room for a write to a full FIFO.
    assign push         = wr_txdata && !full;
    assign unused_wdata = ^WriteIO[31:8];

    // FIFO storage array, written on every accepted push.
    // NOTE: the data array has no reset; count and pointers alone decide
    // which entries are valid, so clearing the storage buys nothing.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= WriteIO[7:0];
    end

    // FIFO pointers and occupancy count.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Control register: EN bit and sticky overflow flag (overflow wins a clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (wr_ctrl) en <= WriteIO[0];
            if (wr_txdata && full)        ovf <= 1'b1;
            else if (wr_ctrl && WriteIO[1]) ovf <= 1'b0;
        end
    end

    // Transmit FSM next-state, counters, shifter and pop decision.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (en && !empty) begin
                    pop       = 1'b1;
                    shift_n   = fifo_mem[rd_ptr];
                    bit_cnt_n = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_n = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_n = '0;
                    shift_n   = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = 3'd0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_n = '0;
                    // Chain straight into the next frame when more data waits.
                    if (en && !empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level for the coming cycle, registered below for a clean tx.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // FSM state, counters, shifter and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= (state_n != IDLE);
        end
    end

    // Register read mux; TXDATA and unmapped addresses read as zero.
    always_comb begin
        ReadIO = 32'd0;
        if (IOAdr == ADR_STATUS)    ReadIO = {26'd0, ovf, count, empty, full};
        else if (IOAdr == ADR_CTRL) ReadIO = {31'd0, en};
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: scoreboard bench for io_uart_tx. Bytes expected on the line
// are queued when written; a line monitor decodes each frame and the tests
// pop the scoreboard against the decoded frames.
module tb_io_uart_tx;

    localparam int         CPB   = 16;
    localparam int         FRAME = 10 * CPB;
    localparam logic [4:0] A_TX  = 5'h10;
    localparam logic [4:0] A_ST  = 5'h14;
    localparam logic [4:0] A_CT  = 5'h18;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [4:0]  IOAdr   = 5'd0;
    logic [31:0] WriteIO = 32'd0;
    logic        IOWrite = 1'b0;
    logic [31:0] ReadIO;
    logic        tx;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_write_cyc;

    typedef struct {
        logic [7:0] data;
        bit         ok;
        int         start;
    } frame_t;

    logic [7:0] exp_q [$];
    frame_t     rx_q  [$];
    int         rx_idx = 0;

    io_uart_tx #(.CLKS_PER_BIT(CPB), .BASE(5'h10)) dut (
        .clk     (clk),
        .reset   (reset),
        .IOAdr   (IOAdr),
        .WriteIO (WriteIO),
        .IOWrite (IOWrite),
        .ReadIO  (ReadIO),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples on the falling clock edge, records each bit's
    // level, requires it steady for CPB samples and busy high throughout.
    bit         mon_active = 1'b0;
    int         mon_k;
    int         mon_start;
    bit         mon_ok;
    logic [9:0] mon_bits;

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                mon_active = 1'b1;
                mon_k      = 0;
                mon_ok     = 1'b1;
                mon_start  = cyc;
            end
            if (mon_active) begin
                if (mon_k % CPB == 0) mon_bits[mon_k / CPB] = tx;
                else if (tx !== mon_bits[mon_k / CPB]) mon_ok = 1'b0;
                if (busy !== 1'b1) mon_ok = 1'b0;
                mon_k++;
                if (mon_k == FRAME) begin
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) mon_ok = 1'b0;
                    rx_q.push_back('{data: mon_bits[8:1], ok: mon_ok, start: mon_start});
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Bus write for one clock; bytes that must appear on the line are queued.
    task automatic io_write(input logic [4:0] adr, input logic [31:0] data, input bit expect_tx);
        IOAdr   = adr;
        WriteIO = data;
        IOWrite = 1'b1;
        if (expect_tx) exp_q.push_back(data[7:0]);
        @(posedge clk);
        #1;
        IOWrite        = 1'b0;
        last_write_cyc = cyc;
    endtask

    task automatic io_read(input logic [4:0] adr, output logic [31:0] data);
        IOAdr = adr;
        #1;
        data = ReadIO;
    endtask

    // Wait (bounded) for n decoded frames and pop the scoreboard against them.
    task automatic scoreboard_drain(input int n, output int first_idx);
        int budget;
        budget    = n * FRAME + 4 * CPB;
        first_idx = rx_idx;
        while (rx_q.size() < rx_idx + n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (rx_q.size() < rx_idx + n) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: got %0d frames, required %0d", rx_q.size() - rx_idx, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                frame_t     f;
                logic [7:0] e;
                f = rx_q[rx_idx];
                rx_idx++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                vectors++;
                if (f.data !== e || !f.ok) begin
                    miscompares++;
                    $display("FAIL frame_%0d: byte %h wave_ok %0d, required byte %h wave_ok 1",
                             i, f.data, f.ok, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_line: tx %b busy %b, required tx 1 busy 0", tx, busy);
        end
        reset = 1'b0;
        sync();
        io_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL reset_status: %h, required %h", rd, 32'h2);
        end
        io_read(A_CT, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_ctrl: %h, required %h", rd, 32'h0);
        end
    endtask

    task automatic test_single_frame();
        int idx;
        int wc;
        sync();
        io_write(A_CT, 32'h1, 1'b0);
        io_write(A_TX, 32'hA5, 1'b1);
        wc = last_write_cyc;
        scoreboard_drain(1, idx);
        if (rx_q.size() > idx) begin
            vectors++;
            if (rx_q[idx].start !== wc + 1) begin
                miscompares++;
                $display("FAIL first_edge: start cycle %0d, required %0d", rx_q[idx].start, wc + 1);
            end
        end
        sync();
        vectors++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL after_frame: tx %b busy %b, required tx 1 busy 0", tx, busy);
        end
    endtask

    task automatic test_back_to_back();
        int          idx;
        logic [31:0] rd;
        sync();
        io_write(A_TX, 32'h01, 1'b1);
        io_write(A_TX, 32'h02, 1'b1);
        io_write(A_TX, 32'h03, 1'b1);
        scoreboard_drain(3, idx);
        if (rx_q.size() >= idx + 3) begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (rx_q[idx + i].start - rx_q[idx + i - 1].start !== FRAME) begin
                    miscompares++;
                    $display("FAIL b2b_gap_%0d: spacing %0d, required %0d", i,
                             rx_q[idx + i].start - rx_q[idx + i - 1].start, FRAME);
                end
            end
        end
        sync();
        io_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL b2b_status: %h, required %h", rd, 32'h2);
        end
    endtask

    task automatic test_overflow();
        int          idx;
        logic [31:0] rd;
        sync();
        io_write(A_CT, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) io_write(A_TX, 32'h10 + i, (i < 4));
        io_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h31) begin
            miscompares++;
            $display("FAIL ovf_status: %h, required %h", rd, 32'h31);
        end
        sync();
        io_write(A_CT, 32'h1, 1'b0);
        scoreboard_drain(4, idx);
        repeat (2 * FRAME) @(negedge clk);
        vectors++;
        if (rx_q.size() !== rx_idx) begin
            miscompares++;
            $display("FAIL ovf_extra: %0d extra frames, required 0", rx_q.size() - rx_idx);
        end
        sync();
        io_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h22) begin
            miscompares++;
            $display("FAIL ovf_drained: %h, required %h", rd, 32'h22);
        end
    endtask

    task automatic test_ovf_clear();
        logic [31:0] rd;
        sync();
        io_write(A_CT, 32'h3, 1'b0);
        io_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL ovf_clear_status: %h, required %h", rd, 32'h2);
        end
        io_read(A_CT, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL ovf_clear_ctrl: %h, required %h", rd, 32'h1);
        end
        io_read(5'h00, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL read_adr0: %h, required %h", rd, 32'h0);
        end
        io_read(A_TX, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL read_txdata: %h, required %h", rd, 32'h0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        sync();
        io_write(A_TX, 32'h3C, 1'b0);
        repeat (50) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: tx %b busy %b, required tx 1 busy 0", tx, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sync();
        io_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL reset_mid_status: %h, required %h", rd, 32'h2);
        end
        io_read(A_CT, rd);
        vectors++;
        if (rd !== 32'h0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_ctrl: ctrl %h tx %b, required ctrl 0 tx 1", rd, tx);
        end
    endtask

    task automatic test_en_clear();
        int          idx;
        int          bad;
        logic [31:0] rd;
        sync();
        io_write(A_CT, 32'h1, 1'b0);
        io_write(A_TX, 32'h5A, 1'b1);
        io_write(A_TX, 32'hC3, 1'b0);
        io_write(A_TX, 32'h7E, 1'b0);
        // Frame started one cycle after the first byte; land in data bit 3.
        repeat (66) @(posedge clk);
        #1;
        io_write(A_CT, 32'h0, 1'b0);
        scoreboard_drain(1, idx);
        sync();
        io_read(A_ST, rd);
        vectors++;
        if (rd !== 32'h08) begin
            miscompares++;
            $display("FAIL en_clear_status: %h, required %h", rd, 32'h08);
        end
        bad = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0 || rx_q.size() !== rx_idx) begin
            miscompares++;
            $display("FAIL en_clear_idle: %0d active cycles, %0d extra frames, required 0 and 0",
                     bad, rx_q.size() - rx_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_ovf_clear();
        test_reset_mid_frame();
        test_en_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
